// File: rtl/ramp_adc_sequencer_pkg.sv
// Shared definitions for the ramp ADC sequencer: state encoding and the
// synchroniser-latency compensation used when a comparator fall is captured.
package ramp_adc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SETTLE    = 2'd1,
        ST_RAMP_UP   = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } state_e;

    // The fall is seen this many counts after the comparator actually tripped.
    localparam int unsigned SYNC_LAT = 2;

    function automatic int unsigned lat_comp(input int unsigned cnt);
        return (cnt > SYNC_LAT) ? (cnt - SYNC_LAT) : 0;
    endfunction

endpackage

// File: rtl/ramp_adc_sequencer_comp_sync_edge.sv
// Two-flop synchroniser for the asynchronous comparator output, followed by
// a history flop that yields a one-cycle falling-edge pulse.
module comp_sync_edge
    import ramp_adc_sequencer_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic comp_i,
    output logic comp_s_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= comp_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign comp_s_o = sync_q;
    assign fall_o   = prev_q & ~sync_q;

endmodule

// File: rtl/ramp_adc_sequencer.sv
// Round-robin triangle-ramp ADC controller: settles the analog mux, counts the
// ramp up, captures the comparator crossing, ramps down and publishes a result.
module ramp_adc_sequencer
    import ramp_adc_sequencer_pkg::*;
#(
    parameter int WIDTH      = 7,
    parameter int FULL_SCALE = 99,
    parameter int N_CH       = 2,
    parameter int SETTLE     = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    comp,
    output logic [2:0]              mux_sel,
    output logic                    ramp_up,
    output logic                    busy,
    output logic [N_CH*WIDTH-1:0]   results,
    output logic [N_CH-1:0]         ovf,
    output logic                    res_valid,
    output logic [2:0]              res_ch
);

    localparam int              SW          = $clog2(SETTLE);
    localparam logic [WIDTH-1:0] FS         = WIDTH'(FULL_SCALE);
    localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [2:0]      LAST_CH     = 3'(N_CH - 1);

    state_e                  state_q, state_d;
    logic [WIDTH-1:0]        count_q, count_d;
    logic [SW-1:0]           settle_q, settle_d;
    logic [2:0]              ch_q, ch_d;
    logic [WIDTH-1:0]        hold_q, hold_d;
    logic                    captured_q, captured_d;
    logic [N_CH-1:0]         ovf_q, ovf_d;
    logic [N_CH*WIDTH-1:0]   results_q, results_d;
    logic                    res_valid_q, res_valid_d;
    logic [2:0]              res_ch_q, res_ch_d;

    logic comp_s;
    logic fall;

    comp_sync_edge u_sync (
        .clk      (clk),
        .rst_n    (reset),
        .comp_i   (comp),
        .comp_s_o (comp_s),
        .fall_o   (fall)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (enable) state_d = ST_SETTLE;
            ST_SETTLE:    if (settle_q == SETTLE_LAST) state_d = ST_RAMP_UP;
            ST_RAMP_UP:   if (count_q == FS) state_d = ST_RAMP_DOWN;
            ST_RAMP_DOWN: if (count_q == FS) state_d = enable ? ST_SETTLE : ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ramp_up = (state_q == ST_RAMP_UP);
        busy    = (state_q != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q     <= '0;
            settle_q    <= '0;
            ch_q        <= '0;
            hold_q      <= '0;
            captured_q  <= 1'b0;
            ovf_q       <= '0;
            results_q   <= '0;
            res_valid_q <= 1'b0;
            res_ch_q    <= '0;
        end else begin
            count_q     <= count_d;
            settle_q    <= settle_d;
            ch_q        <= ch_d;
            hold_q      <= hold_d;
            captured_q  <= captured_d;
            ovf_q       <= ovf_d;
            results_q   <= results_d;
            res_valid_q <= res_valid_d;
            res_ch_q    <= res_ch_d;
        end
    end

    // Counters fall back to zero outside their own state, so every state starts counting at 0.
    always_comb begin
        count_d     = '0;
        settle_d    = '0;
        ch_d        = ch_q;
        hold_d      = hold_q;
        captured_d  = captured_q;
        ovf_d       = ovf_q;
        results_d   = results_q;
        res_valid_d = 1'b0;
        res_ch_d    = res_ch_q;

        case (state_q)
            ST_SETTLE: begin
                captured_d = 1'b0;
                if (settle_q != SETTLE_LAST) settle_d = settle_q + 1'b1;
            end
            ST_RAMP_UP: begin
                if (count_q != FS) count_d = count_q + 1'b1;
                if (!captured_q) begin
                    if (count_q == '0 && !comp_s) begin
                        hold_d     = '0;
                        captured_d = 1'b1;
                        for (int k = 0; k < N_CH; k++)
                            if (ch_q == 3'(k)) ovf_d[k] = 1'b0;
                    end else if (fall) begin
                        hold_d     = WIDTH'(lat_comp(32'(count_q)));
                        captured_d = 1'b1;
                        for (int k = 0; k < N_CH; k++)
                            if (ch_q == 3'(k)) ovf_d[k] = 1'b0;
                    end else if (count_q == FS) begin
                        hold_d     = FS;
                        captured_d = 1'b1;
                        for (int k = 0; k < N_CH; k++)
                            if (ch_q == 3'(k)) ovf_d[k] = 1'b1;
                    end
                end
            end
            ST_RAMP_DOWN: begin
                if (count_q != FS) begin
                    count_d = count_q + 1'b1;
                end else begin
                    for (int k = 0; k < N_CH; k++)
                        if (ch_q == 3'(k)) results_d[k*WIDTH +: WIDTH] = hold_q;
                    res_valid_d = 1'b1;
                    res_ch_d    = ch_q;
                    ch_d        = (ch_q == LAST_CH) ? 3'd0 : ch_q + 3'd1;
                end
            end
            default: ;
        endcase
    end

    assign mux_sel   = ch_q;
    assign results   = results_q;
    assign ovf       = ovf_q;
    assign res_valid = res_valid_q;
    assign res_ch    = res_ch_q;

endmodule

// File: tb/tb_ramp_adc_sequencer.sv
// Directed bench for ramp_adc_sequencer (two channels, default widths):
// drives the comparator at chosen ramp counts and checks the reported results.
module tb_ramp_adc_sequencer;

    localparam int WIDTH = 7;
    localparam int N_CH  = 2;

    logic                  clk    = 1'b0;
    logic                  reset  = 1'b0;
    logic                  enable = 1'b0;
    logic                  comp   = 1'b1;
    logic [2:0]            mux_sel;
    logic                  ramp_up;
    logic                  busy;
    logic [N_CH*WIDTH-1:0] results;
    logic [N_CH-1:0]       ovf;
    logic                  res_valid;
    logic [2:0]            res_ch;

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc     = 0;
    int unsigned valid_cyc;

    ramp_adc_sequencer #(
        .WIDTH      (WIDTH),
        .FULL_SCALE (99),
        .N_CH       (N_CH),
        .SETTLE     (4)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .comp      (comp),
        .mux_sel   (mux_sel),
        .ramp_up   (ramp_up),
        .busy      (busy),
        .results   (results),
        .ovf       (ovf),
        .res_valid (res_valid),
        .res_ch    (res_ch)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // fall_at: count at which comp drops (0 = low throughout, -1 = never drops).
    task automatic do_conv(input int exp_ch, input int fall_at, input bit glitch,
                           input int drop_at, input int exp_res, input bit exp_ovf);
        int t;
        comp = (fall_at == 0) ? 1'b0 : 1'b1;
        t = 0;
        while (ramp_up !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (ramp_up !== 1'b1) begin
            check("ramp_up_timeout", 64'd0, 64'd1);
            return;
        end
        check($sformatf("mux_sel_ch%0d", exp_ch), 64'(mux_sel), 64'(exp_ch));
        for (int c = 1; c <= 99; c++) begin
            @(negedge clk);
            if (c == fall_at) comp = 1'b0;
            if (glitch && c == 25) comp = 1'b1;
            if (glitch && c == 30) comp = 1'b0;
            if (c == drop_at) enable = 1'b0;
        end
        t = 0;
        while (res_valid !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (res_valid !== 1'b1) begin
            check("res_valid_timeout", 64'd0, 64'd1);
            return;
        end
        valid_cyc = cyc;
        check($sformatf("res_ch_%0d", exp_ch), 64'(res_ch), 64'(exp_ch));
        check($sformatf("result_ch%0d", exp_ch),
              (64'(results) >> (exp_ch * WIDTH)) & 64'h7F, 64'(exp_res));
        check($sformatf("ovf_ch%0d", exp_ch), (64'(ovf) >> exp_ch) & 64'd1, 64'(exp_ovf));
        $display("[TB] conv ch=%0d result=%0d ovf=%0d cycle=%0d", exp_ch,
                 (64'(results) >> (exp_ch * WIDTH)) & 64'h7F, (64'(ovf) >> exp_ch) & 64'd1, cyc);
    endtask

    initial begin
        int unsigned t_first;
        int          bad;

        // Reset held low with enable off.
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_mux_sel", 64'(mux_sel), 64'd0);
        check("rst_ramp_up", 64'(ramp_up), 64'd0);
        check("rst_results", 64'(results), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_ch", 64'(res_ch), 64'd0);
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || ramp_up !== 1'b0 || res_valid !== 1'b0 || mux_sel !== 3'd0) bad++;
        end
        check("idle_50_cycles_bad", 64'(bad), 64'd0);
        $display("[TB] reset/idle done");

        enable = 1'b1;
        do_conv(0, 40, 1'b0, -1, 40, 1'b0);
        t_first = valid_cyc;
        do_conv(1, 75, 1'b0, -1, 75, 1'b0);
        check("period", 64'(valid_cyc - t_first), 64'd204);
        do_conv(0, 10, 1'b0, -1, 10, 1'b0);
        check("bank_75_10", 64'(results), 64'd9610);
        do_conv(1, 0, 1'b0, -1, 0, 1'b0);
        do_conv(0, -1, 1'b0, -1, 99, 1'b1);
        check("bank_0_99", 64'(results), 64'd99);
        check("ovf_bank_01", 64'(ovf), 64'd1);
        do_conv(1, 20, 1'b1, -1, 20, 1'b0);
        check("ovf_after_glitch", 64'(ovf), 64'd1);

        // Enable dropped mid ramp-up: this conversion still reports, then idle.
        do_conv(0, 50, 1'b0, 60, 50, 1'b0);
        check("drop_busy", 64'(busy), 64'd0);
        check("drop_mux_sel", 64'(mux_sel), 64'd1);
        check("bank_20_50", 64'(results), 64'd2610);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || res_valid !== 1'b0 || mux_sel !== 3'd1) bad++;
        end
        check("drop_idle_bad", 64'(bad), 64'd0);
        $display("[TB] enable drop done");

        // Asynchronous reset in the middle of ramp-down on channel 1.
        comp   = 1'b1;
        enable = 1'b1;
        bad = 0;
        while (ramp_up !== 1'b1 && bad < 400) begin
            @(negedge clk);
            bad++;
        end
        check("areset_ramp_seen", 64'(ramp_up), 64'd1);
        check("areset_ch", 64'(mux_sel), 64'd1);
        for (int c = 1; c <= 99; c++) begin
            @(negedge clk);
            if (c == 30) comp = 1'b0;
        end
        repeat (20) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("areset_busy", 64'(busy), 64'd0);
        check("areset_mux_sel", 64'(mux_sel), 64'd0);
        check("areset_results", 64'(results), 64'd0);
        check("areset_ovf", 64'(ovf), 64'd0);
        check("areset_res_valid", 64'(res_valid), 64'd0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (res_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("areset_hold_bad", 64'(bad), 64'd0);
        comp  = 1'b1;
        reset = 1'b1;
        $display("[TB] async reset done");
        do_conv(0, 15, 1'b0, -1, 15, 1'b0);
        check("restart_bank", 64'(results), 64'd15);
        check("restart_ovf", 64'(ovf), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
